fadd_align_ctrl: RTL

//  Multi-cycle alignment sequencer for the FP64 adder front end. It accepts an operand pair
//  (biased exponents plus significands with hidden bit) and forms the exponent difference
//  ea - eb (12-bit two's complement, sign = eb_gt_ea). It swaps operands so the larger

---
 rtl/fadd_align_ctrl.sv | 136 +++++++++++++
 1 files changed

// File: rtl/fadd_align_ctrl.sv
// Alignment sequencer for the FP64 adder front end: picks the larger-exponent operand and
// right-shifts the smaller significand STEP bits per cycle, folding lost bits into sticky.
module fadd_align_ctrl #(
   parameter int unsigned EXP_W = 11,
   parameter int unsigned MAN_W = 53,
   parameter int unsigned STEP  = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [EXP_W-1:0]   ea,
   input  logic [EXP_W-1:0]   eb,
   input  logic [MAN_W-1:0]   ma,
   input  logic [MAN_W-1:0]   mb,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [EXP_W-1:0]   e_max,
   output logic [MAN_W-1:0]   m_big,
   output logic [MAN_W+2:0]   m_small,
   output logic               swapped,
   output logic               busy
);

   localparam int unsigned MS_W  = MAN_W + 3;
   localparam int unsigned AMT_W = $clog2(MS_W + 1);

   typedef enum logic [1:0] {StIdle, StSub, StShift, StDone} state_e;

   state_e             state_q, state_d;
   logic [EXP_W-1:0]   ea_q, ea_d, eb_q, eb_d;
   logic [MAN_W-1:0]   ma_q, ma_d, mb_q, mb_d;
   logic [EXP_W-1:0]   e_max_q, e_max_d;
   logic [MAN_W-1:0]   m_big_q, m_big_d;
   logic [MS_W-1:0]    m_small_q, m_small_d;
   logic               swapped_q, swapped_d;
   logic [AMT_W-1:0]   amt_q, amt_d;

   logic [EXP_W:0]     diff;
   logic [EXP_W-1:0]   mag;
   logic [AMT_W-1:0]   amt_clamp;
   logic [AMT_W-1:0]   k;
   logic               lost;
   logic [MS_W-1:0]    shifted;

   // Exponent difference as ea + ~eb + 1; the top bit is the "eb > ea" sign.
   always_comb begin
      diff      = {1'b0, ea_q} + {1'b1, ~eb_q} + (EXP_W + 1)'(1);
      mag       = diff[EXP_W] ? EXP_W'(-diff) : EXP_W'(diff);
      amt_clamp = (mag >= EXP_W'(MS_W)) ? AMT_W'(MS_W) : AMT_W'(mag);

      k    = (amt_q > AMT_W'(STEP)) ? AMT_W'(STEP) : amt_q;
      lost = 1'b0;
      for (int i = 0; i < int'(MS_W); i++) begin
         if (i < int'(k)) lost = lost | m_small_q[i];
      end
      shifted    = m_small_q >> k;
      shifted[0] = shifted[0] | lost;
   end

   always_comb begin
      state_d   = state_q;
      ea_d      = ea_q;
      eb_d      = eb_q;
      ma_d      = ma_q;
      mb_d      = mb_q;
      e_max_d   = e_max_q;
      m_big_d   = m_big_q;
      m_small_d = m_small_q;
      swapped_d = swapped_q;
      amt_d     = amt_q;
      unique case (state_q)
         StIdle: begin
            if (in_valid) begin
               ea_d    = ea;
               eb_d    = eb;
               ma_d    = ma;
               mb_d    = mb;
               state_d = StSub;
            end
         end
         StSub: begin
            swapped_d = diff[EXP_W];
            e_max_d   = diff[EXP_W] ? eb_q : ea_q;
            m_big_d   = diff[EXP_W] ? mb_q : ma_q;
            m_small_d = {(diff[EXP_W] ? ma_q : mb_q), 3'b000};
            amt_d     = amt_clamp;
            state_d   = (amt_clamp == '0) ? StDone : StShift;
         end
         StShift: begin
            m_small_d = shifted;
            amt_d     = amt_q - k;
            if (amt_q == k) state_d = StDone;
         end
         StDone: begin
            if (out_ready) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         ea_q      <= '0;
         eb_q      <= '0;
         ma_q      <= '0;
         mb_q      <= '0;
         e_max_q   <= '0;
         m_big_q   <= '0;
         m_small_q <= '0;
         swapped_q <= 1'b0;
         amt_q     <= '0;
      end else begin
         state_q   <= state_d;
         ea_q      <= ea_d;
         eb_q      <= eb_d;
         ma_q      <= ma_d;
         mb_q      <= mb_d;
         e_max_q   <= e_max_d;
         m_big_q   <= m_big_d;
         m_small_q <= m_small_d;
         swapped_q <= swapped_d;
         amt_q     <= amt_d;
      end
   end

   assign in_ready  = (state_q == StIdle);
   assign busy      = (state_q != StIdle);
   assign out_valid = (state_q == StDone);
   assign e_max     = e_max_q;
   assign m_big     = m_big_q;
   assign m_small   = m_small_q;
   assign swapped   = swapped_q;

endmodule
